lsu_mem_initiator: RTL and testbench

- Load/store initiator for the word-indexed data memory; it drives the memory's address, write-data, opcode and write-enable, and captures its registered read data.
- Accepts one LOAD or STORE at a time from the execute stage with a valid/ready handshake.
- Sequences the memory access through a small FSM.
- Returns load results to register-file writeback as a one-cycle pulse.

---
 rtl/lsu_mem_initiator.sv | 137 +++++++++++++
 tb/tb_lsu_mem_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the word-indexed data memory: one LOAD/STORE at a time, IDLE->ISSUE(->CAPTURE->WB).
// Optional range check on the word index is enabled with `define LSU_RANGE_CHECK_EN (adds the err port).
module lsu_mem_initiator #(
    parameter logic [5:0] LOAD      = 6'b000100,
    parameter logic [5:0] STORE     = 6'b000101,
    parameter int         MEM_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opc,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datain,
    output logic [5:0]  mem_opc,
    output logic        mem_wea,
    input  logic [31:0] mem_dataout,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
`ifdef LSU_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WB
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic        is_load_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        is_mem_op;
    logic        addr_below_limit;
    logic        addr_ok;
    logic        start_access;

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign accept           = req_valid && req_ready;
    assign is_mem_op        = (req_opc == LOAD) || (req_opc == STORE);
    assign addr_below_limit = (req_addr < ADDR_LIMIT);

`ifdef LSU_RANGE_CHECK_EN
    logic reject_access;
    assign addr_ok       = addr_below_limit;
    assign reject_access = accept && is_mem_op && !addr_ok;
`else
    // Without the check every index goes to the memory unchanged.
    logic unused_range;
    assign unused_range = addr_below_limit;
    assign addr_ok      = 1'b1;
`endif

    assign start_access = accept && is_mem_op && addr_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_access) state_d = ISSUE;
            ISSUE:   state_d = is_load_q ? CAPTURE : IDLE;
            CAPTURE: state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory controls are registered so they are stable for the whole ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_datain  <= '0;
            mem_opc     <= '0;
            mem_wea     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            is_load_q   <= 1'b0;
            rd_q        <= '0;
`ifdef LSU_RANGE_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef LSU_RANGE_CHECK_EN
            err      <= (state_q == IDLE) && reject_access;
`endif
            unique case (state_q)
                IDLE: begin
                    if (start_access) begin
                        mem_address <= req_addr;
                        mem_datain  <= req_wdata;
                        mem_opc     <= req_opc;
                        mem_wea     <= (req_opc == STORE);
                        is_load_q   <= (req_opc == LOAD);
                        rd_q        <= req_rd;
                    end
                end
                ISSUE: begin
                    mem_opc <= '0;
                    mem_wea <= 1'b0;
                end
                CAPTURE: begin
                    wb_data  <= mem_dataout;
                    wb_rd    <= rd_q;
                    wb_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed table, reset/range corners, randomized traffic vs. a sequential model.
// Build with +define+LSU_RANGE_CHECK_EN to exercise the range-checked variant.
module tb_lsu_mem_initiator;

    localparam logic [5:0] LOAD  = 6'b000100;
    localparam logic [5:0] STORE = 6'b000101;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic [5:0]  mem_opc;
    logic        mem_wea;
    logic [31:0] mem_dataout;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
`ifdef LSU_RANGE_CHECK_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    lsu_mem_initiator dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opc     (req_opc),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .mem_address (mem_address),
        .mem_datain  (mem_datain),
        .mem_opc     (mem_opc),
        .mem_wea     (mem_wea),
        .mem_dataout (mem_dataout),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy)
`ifdef LSU_RANGE_CHECK_EN
        ,
        .err         (err)
`endif
    );

    always #5 clock = ~clock;

    // Data memory fixture: no reset, write on WEA, registered read on LOAD opcode.
    logic [31:0] sram [8];
    always @(posedge clock) begin
        if (mem_wea) sram[mem_address[2:0]] <= mem_datain;
        if (mem_opc == LOAD) mem_dataout <= sram[mem_address[2:0]];
    end

    // Architectural view of memory, updated in request order.
    logic [31:0] exp_mem [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        req_valid = v;
        req_opc   = o;
        req_addr  = a;
        req_wdata = d;
        req_rd    = r;
    endtask

    typedef struct {
        logic [5:0]  opc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        exp_wb;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        int          exp_wea_n;
        int          exp_busy_n;
    } vec_t;

    vec_t tbl [9];

    task automatic run_row(input int idx, input vec_t v);
        int         wea_n  = 0;
        int         wb_n   = 0;
        int         wb_at  = 0;
        int         busy_n = 0;
        logic [5:0] opc_c1 = '0;
        logic [5:0] exp_opc;
        @(negedge clock);
        drive(1'b1, v.opc, v.addr, v.wdata, v.rd);
        check($sformatf("row%0d_ready", idx), req_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (c == 1) opc_c1 = mem_opc;
            if (mem_wea) wea_n++;
            if (busy) busy_n++;
            if (wb_valid) begin
                wb_n++;
                if (wb_at == 0) wb_at = c;
            end
        end
        exp_opc = (v.opc == LOAD || v.opc == STORE) ? v.opc : 6'b0;
        if (v.opc == STORE) exp_mem[v.addr[2:0]] = v.wdata;
        check($sformatf("row%0d_opc", idx), opc_c1, exp_opc);
        check($sformatf("row%0d_wea_cycles", idx), wea_n, v.exp_wea_n);
        check($sformatf("row%0d_busy_cycles", idx), busy_n, v.exp_busy_n);
        check($sformatf("row%0d_wb_pulses", idx), wb_n, v.exp_wb ? 1 : 0);
        if (v.exp_wb) check($sformatf("row%0d_wb_latency", idx), wb_at, 3);
        check($sformatf("row%0d_wb_data", idx), wb_data, v.exp_data);
        check($sformatf("row%0d_wb_rd", idx), wb_rd, v.exp_rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_addr"}, mem_address, 32'h0);
        check({tag, "_datain"}, mem_datain, 32'h0);
        check({tag, "_opc"}, mem_opc, 6'h0);
        check({tag, "_wea"}, mem_wea, 1'b0);
        check({tag, "_wb_valid"}, wb_valid, 1'b0);
        check({tag, "_wb_rd"}, wb_rd, 5'h0);
        check({tag, "_wb_data"}, wb_data, 32'h0);
`ifdef LSU_RANGE_CHECK_EN
        check({tag, "_err"}, err, 1'b0);
`endif
    endtask

    typedef struct {
        logic [5:0]  opc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } wb_t;

    task automatic run_random(input int n_rand);
        req_t reqs[$];
        wb_t  wbq[$];
        int   weaq[$];
        int   cyc = 0;
        int   i = 0;
        int   busy_left = 0;
        bit   done = 0;
        bit   exp_wb;
        bit   exp_wea;
        // Back-to-back STORE/LOAD pairs first, then a random mix.
        for (int k = 0; k < 3; k++) begin
            reqs.push_back('{STORE, 32'(4 + k), $urandom, 5'd0});
            reqs.push_back('{LOAD, 32'(4 + k), 32'h0, 5'(2 + k)});
        end
        for (int k = 0; k < n_rand; k++) begin
            int sel = $urandom_range(0, 9);
            logic [5:0] o = (sel < 4) ? LOAD : (sel < 8) ? STORE : 6'($urandom_range(0, 3));
            reqs.push_back('{o, 32'($urandom_range(0, 7)), $urandom, 5'($urandom)});
        end
        while (!done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            if (i < reqs.size())
                drive(1'b1, reqs[i].opc, reqs[i].addr, reqs[i].wdata, reqs[i].rd);
            else
                req_valid = 1'b0;
            check("rnd_ready", req_ready, busy_left == 0);
            check("rnd_busy", busy, busy_left != 0);
            exp_wb = (wbq.size() > 0) && (wbq[0].due == cyc);
            check("rnd_wb_valid", wb_valid, exp_wb);
            if (exp_wb) begin
                check("rnd_wb_data", wb_data, wbq[0].data);
                check("rnd_wb_rd", wb_rd, wbq[0].rd);
                void'(wbq.pop_front());
            end
            exp_wea = (weaq.size() > 0) && (weaq[0] == cyc);
            check("rnd_wea", mem_wea, exp_wea);
            if (exp_wea) void'(weaq.pop_front());
            if (busy_left > 0) begin
                busy_left--;
            end else if (i < reqs.size()) begin
                if (reqs[i].opc == STORE) begin
                    exp_mem[reqs[i].addr[2:0]] = reqs[i].wdata;
                    weaq.push_back(cyc + 1);
                    busy_left = 1;
                end else if (reqs[i].opc == LOAD) begin
                    wbq.push_back('{exp_mem[reqs[i].addr[2:0]], reqs[i].rd, cyc + 3});
                    busy_left = 3;
                end
                i++;
            end else if (wbq.size() == 0 && weaq.size() == 0) begin
                done = 1;
            end
        end
        if (!done) check("rnd_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            sram[k]    = 32'(k + 1);
            exp_mem[k] = 32'(k + 1);
        end
        mem_dataout = '0;
        drive(1'b0, 6'h0, 32'h0, 32'h0, 5'h0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("post_reset");

        tbl[0] = '{LOAD,  32'd3, 32'h0,        5'd5,  1'b1, 32'h4,        5'd5,  0, 3};
        tbl[1] = '{STORE, 32'd2, 32'hDEADBEEF, 5'd0,  1'b0, 32'h4,        5'd5,  1, 1};
        tbl[2] = '{LOAD,  32'd2, 32'h0,        5'd7,  1'b1, 32'hDEADBEEF, 5'd7,  0, 3};
        tbl[3] = '{6'h00, 32'd1, 32'h55,       5'd3,  1'b0, 32'hDEADBEEF, 5'd7,  0, 0};
        tbl[4] = '{LOAD,  32'd0, 32'h0,        5'd31, 1'b1, 32'h1,        5'd31, 0, 3};
        tbl[5] = '{STORE, 32'd7, 32'h12345678, 5'd9,  1'b0, 32'h1,        5'd31, 1, 1};
        tbl[6] = '{LOAD,  32'd7, 32'h0,        5'd1,  1'b1, 32'h12345678, 5'd1,  0, 3};
        tbl[7] = '{6'h3F, 32'd5, 32'hFFFF,     5'd4,  1'b0, 32'h12345678, 5'd1,  0, 0};
        tbl[8] = '{LOAD,  32'd6, 32'h0,        5'd0,  1'b1, 32'h7,        5'd0,  0, 3};
        for (int k = 0; k < 9; k++) run_row(k, tbl[k]);

        // Reset during CAPTURE of a load: nothing written back, everything back at reset values.
        @(negedge clock);
        drive(1'b1, LOAD, 32'd1, 32'h0, 5'd9);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("capture_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        reset = 1'b0;

        // Request coinciding with reset is not accepted.
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, STORE, 32'd0, 32'hBAD0BAD0, 5'd0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        check("rst_req_busy", busy, 1'b0);
        check("rst_req_wea", mem_wea, 1'b0);
        @(negedge clock);
        check("rst_req_wea_late", mem_wea, 1'b0);
        check("rst_req_addr", mem_address, 32'h0);

        // Out-of-range store to word 9.
        begin
            int wea_n = 0;
            int busy_n = 0;
            int err_n = 0;
            int err_at = 0;
            @(negedge clock);
            drive(1'b1, STORE, 32'd9, 32'hA5A5A5A5, 5'd0);
            check("range_ready", req_ready, 1'b1);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clock);
                req_valid = 1'b0;
                if (mem_wea) wea_n++;
                if (busy) busy_n++;
`ifdef LSU_RANGE_CHECK_EN
                if (err) begin
                    err_n++;
                    if (err_at == 0) err_at = c;
                end
`endif
            end
`ifdef LSU_RANGE_CHECK_EN
            check("range_err_pulses", err_n, 1);
            check("range_err_cycle", err_at, 1);
            check("range_wea_cycles", wea_n, 0);
            check("range_busy_cycles", busy_n, 0);
`else
            exp_mem[1] = 32'hA5A5A5A5;
            check("range_err_pulses", err_n, 0);
            check("range_wea_cycles", wea_n, 1);
            check("range_busy_cycles", busy_n, 1);
            check("range_err_cycle", err_at, 0);
`endif
            check("range_mem1", sram[1], exp_mem[1]);
        end

        run_random(40);

        @(negedge clock);
        for (int k = 0; k < 8; k++) check($sformatf("final_mem%0d", k), sram[k], exp_mem[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
